div_clk_bcd_counter: RTL and testbench
======================================

Name: div_clk_bcd_counter

Overview:
- Consumer end of the divided-clock interface: takes the slow toggling `divider_clk` produced by the clock divider as a plain data input.
- Samples it in the fast `clk` domain, detects rising edges, and advances a 4-digit BCD counter that feeds the seven-segment driver.
- Flags a stalled divider when no rising edge arrives within a configurable number of `clk` cycles.
- No logic is clocked by `divider_clk`.

Parameters:
- STALL_LIMIT, default 150000000: `clk` cycles since the last detected rising edge at which `stalled` asserts. Must be ≥ 2.
- GAP_W, default 28: width of the gap counter. Must satisfy 2^GAP_W > STALL_LIMIT.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- divider_clk  input  1  slow clock from the divider, treated as asynchronous data.
- enable  input  1  count enable, sampled on posedge clk.
- clear  input  1  synchronous count clear.
- bcd_out  output  16  four BCD digits; [15:12] = thousands … [3:0] = units.
- tick  output  1  one-cycle pulse per accepted `divider_clk` rising edge.
- carry_out  output  1  one-cycle pulse on 9999→0000 wrap.
- stalled  output  1  level; divider edge overdue.

Behaviour:

Reset (`rst` high, asynchronous assert):
- Sync flops s1, s2 and edge-history flop `prev` go to 0.
- `bcd_out`=0, `tick`=0, `carry_out`=0, `stalled`=0, gap counter=0.
- Reset mid-count discards all state. After release, no tick is generated unless a 0→1 transition is seen through the synchronizer.

Synchronizer / edge detect:
- Each edge: s1<=divider_clk, s2<=s1, prev<=s2.
- `edge` = s2 & ~prev (combinational, internal).
- `tick` is a register: tick<=edge.
- Latency: if `divider_clk` is first sampled high at posedge k, then s2=1 after k+1, `edge` is true during the following cycle, and `tick` is high for exactly the cycle after posedge k+2.
- Level held high produces no further ticks. Falling edges are ignored.
- Minimum resolvable input high or low time: 3 clk cycles.

Counter (updates on the same posedge that sets `tick`, so `bcd_out` changes coincident with `tick` rising):
- Priority 1, `clear`=1: bcd_out<=0, carry_out<=0, regardless of `edge` or `enable`.
- Priority 2, `edge` & `enable`: BCD increment.
  - Units 0–8 → +1.
  - Units 9 → 0 with carry into tens; same rule ripples through hundreds and thousands.
  - 9999 → 0000 with carry_out<=1 for one cycle.
- Otherwise: hold; carry_out<=0.
- `tick` pulses on every edge independent of `enable` and `clear`.
- Digits never hold values A–F. Each is 0–9 at all times.

Stall monitor:
- On `edge`: gap<=0, stalled<=0.
- Else if gap<STALL_LIMIT: gap<=gap+1.
- Else: gap holds (saturates).
- `stalled`<=1 when the next gap value equals STALL_LIMIT.
- `stalled` stays high until the next `edge`, then clears on the same posedge as `tick` rises.
- `enable` and `clear` do not affect the stall monitor.

Test Plan:
Bench parameters: STALL_LIMIT=20, GAP_W=5; `divider_clk` driven with 8 clk high / 8 clk low unless stated.
1. Reset, enable=1, first divider_clk 0→1 sampled at posedge k -> tick high only in cycle after k+2; bcd_out 0x0000→0x0001 on that edge; carry_out=0.
2. Preload by 9 edges, then 1 more -> bcd_out 0x0009→0x0010. Run to 0x0099 and add 1 edge -> 0x0100. No digit ever shows A–F.
3. Run to 0x9999, 1 more edge -> bcd_out=0x0000, carry_out high exactly 1 cycle, coincident with tick.
4. enable=0 for 3 edges -> 3 tick pulses, bcd_out unchanged. clear=1 on the same cycle as an edge with enable=1 -> bcd_out=0x0000, tick still pulses.
5. Hold divider_clk low after last edge -> stalled rises at 20 cycles after the edge, stays high for 50 cycles. Next rising edge -> stalled=0 on the same posedge tick rises.
6. Assert rst while bcd_out=0x0042 and divider_clk high -> all outputs 0 immediately, no tick after release while divider_clk stays high; first new 0→1 -> bcd_out=0x0001.

Source files
------------

// File: rtl/div_clk_bcd_counter.sv
// div_clk_bcd_counter: samples the divider's slow clock as data in the clk
// domain, counts its rising edges in 4-digit BCD and flags a stalled divider.
module div_clk_bcd_counter #(
  parameter int unsigned STALL_LIMIT = 150000000,
  parameter int unsigned GAP_W       = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        divider_clk,
  input  logic        enable,
  input  logic        clear,
  output logic [15:0] bcd_out,
  output logic        tick,
  output logic        carry_out,
  output logic        stalled
);

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned FILL_W = 2;
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(3);
  localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(STALL_LIMIT);

  logic              s1;
  logic              s2;
  logic              prev;
  logic [FILL_W-1:0] fill_q;
  logic              rise_c;
  logic [15:0]       bcd_inc_c;
  logic              wrap_c;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_nxt_c;

  // Two-flop synchronizer plus edge history; fill_q marks when s2/prev hold
  // real post-reset samples so a level already high at release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      prev   <= 1'b0;
      fill_q <= '0;
    end else begin
      s1   <= divider_clk;
      s2   <= s1;
      prev <= s2;
      if (fill_q != FILL_DONE) fill_q <= fill_q + FILL_W'(1);
    end
  end

  assign rise_c = s2 & ~prev & (fill_q == FILL_DONE);

  // BCD increment with digit-to-digit ripple; wrap_c flags 9999 -> 0000.
  always_comb begin : bcd_inc_p
    logic ripple;
    ripple    = 1'b1;
    bcd_inc_c = bcd_out;
    for (int i = 0; i < DIGITS; i++) begin
      if (ripple) begin
        if (bcd_out[i*DIG_W +: DIG_W] == DIG_W'(9)) begin
          bcd_inc_c[i*DIG_W +: DIG_W] = '0;
        end else begin
          bcd_inc_c[i*DIG_W +: DIG_W] = bcd_out[i*DIG_W +: DIG_W] + DIG_W'(1);
          ripple = 1'b0;
        end
      end
    end
    wrap_c = ripple;
  end

  // Tick pulse and counter; clear beats increment, tick ignores both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick      <= 1'b0;
      bcd_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      tick <= rise_c;
      if (clear) begin
        bcd_out   <= '0;
        carry_out <= 1'b0;
      end else if (rise_c && enable) begin
        bcd_out   <= bcd_inc_c;
        carry_out <= wrap_c;
      end else begin
        carry_out <= 1'b0;
      end
    end
  end

  // Next gap value: restart on an edge, otherwise count up and saturate.
  always_comb begin
    gap_nxt_c = gap_q;
    if (rise_c) begin
      gap_nxt_c = '0;
    end else if (gap_q < GAP_LIMIT) begin
      gap_nxt_c = gap_q + GAP_W'(1);
    end
  end

  // Stall monitor registers; stalled tracks the saturated gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q   <= '0;
      stalled <= 1'b0;
    end else begin
      gap_q   <= gap_nxt_c;
      stalled <= (gap_nxt_c == GAP_LIMIT);
    end
  end

endmodule

// File: tb/tb_div_clk_bcd_counter.sv
// Bench for div_clk_bcd_counter: directed and randomized divider waveforms
// checked every cycle against an integer-count reference model.
module tb_div_clk_bcd_counter;

  localparam int unsigned LIMIT = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        divider_clk;
  logic        enable;
  logic        clear;
  logic [15:0] bcd_out;
  logic        tick;
  logic        carry_out;
  logic        stalled;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;

  // reference model state
  int count;
  int since;
  int nsamp;
  bit last_s;
  bit rd1, rd2;
  bit tick_e, carry_e, stalled_e;

  div_clk_bcd_counter #(.STALL_LIMIT(LIMIT), .GAP_W(5)) dut (
    .clk(clk), .rst(rst), .divider_clk(divider_clk), .enable(enable),
    .clear(clear), .bcd_out(bcd_out), .tick(tick), .carry_out(carry_out),
    .stalled(stalled)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    count = 0; since = 0; nsamp = 0; last_s = 0;
    rd1 = 0; rd2 = 0; tick_e = 0; carry_e = 0; stalled_e = 0;
  endtask

  // One clk cycle: advance the model on the posedge, then compare outputs.
  task automatic cycle();
    bit rise_n;
    bit digits_ok;
    @(posedge clk);
    rise_n = divider_clk && !last_s && (nsamp >= 1);
    last_s = divider_clk;
    nsamp++;
    tick_e = rd2;
    rd2 = rd1;
    rd1 = rise_n;
    carry_e = !clear && tick_e && enable && (count == 9999);
    if (clear) count = 0;
    else if (tick_e && enable) count = (count + 1) % 10000;
    if (tick_e) since = 0;
    else if (since < LIMIT) since++;
    stalled_e = (since >= LIMIT);
    #1;
    check("tick", 32'(tick), 32'(tick_e));
    check("bcd_out", 32'(bcd_out), 32'(to_bcd(count)));
    check("carry_out", 32'(carry_out), 32'(carry_e));
    check("stalled", 32'(stalled), 32'(stalled_e));
    digits_ok = 1'b1;
    for (int i = 0; i < 4; i++) if (bcd_out[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
    check("digit_range", 32'(digits_ok), 32'd1);
    if (tick === 1'b1) tick_cnt++;
  endtask

  task automatic pulse(int hi, int lo);
    divider_clk = 1'b1;
    repeat (hi) cycle();
    divider_clk = 1'b0;
    repeat (lo) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_carry", 32'(carry_out), 32'h0);
    check("rst_stalled", 32'(stalled), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : main
    int t0;
    int first_stall;
    int high_cnt;
    int guard;
    divider_clk = 1'b0;
    enable = 1'b1;
    clear = 1'b0;
    do_reset();

    // 1: first edge latency
    repeat (4) cycle();
    divider_clk = 1'b1;
    cycle();
    check("t1_tick_k", 32'(tick), 32'h0);
    cycle();
    check("t1_tick_k1", 32'(tick), 32'h0);
    cycle();
    check("t1_tick_k2", 32'(tick), 32'h1);
    check("t1_bcd", 32'(bcd_out), 32'h0001);
    check("t1_carry", 32'(carry_out), 32'h0);
    cycle();
    check("t1_tick_k3", 32'(tick), 32'h0);
    repeat (4) cycle();
    divider_clk = 1'b0;
    repeat (8) cycle();

    // 2: decade ripples
    repeat (8) pulse(8, 8);
    check("t2_bcd_9", 32'(bcd_out), 32'h0009);
    pulse(8, 8);
    check("t2_bcd_10", 32'(bcd_out), 32'h0010);
    repeat (89) pulse(8, 8);
    check("t2_bcd_99", 32'(bcd_out), 32'h0099);
    pulse(8, 8);
    check("t2_bcd_100", 32'(bcd_out), 32'h0100);

    // 3: run to 9999 at minimum pulse width, then wrap
    guard = 0;
    while (count != 9998 && guard < 12000) begin
      pulse(3, 3);
      guard++;
    end
    check("t3_bcd_9998", 32'(bcd_out), 32'h9998);
    pulse(3, 3);
    check("t3_bcd_9999", 32'(bcd_out), 32'h9999);
    divider_clk = 1'b1;
    repeat (3) cycle();
    check("t3_wrap_tick", 32'(tick), 32'h1);
    check("t3_wrap_bcd", 32'(bcd_out), 32'h0000);
    check("t3_wrap_carry", 32'(carry_out), 32'h1);
    cycle();
    check("t3_carry_once", 32'(carry_out), 32'h0);
    repeat (4) cycle();
    divider_clk = 1'b0;
    repeat (8) cycle();

    // 4: enable low, then clear coincident with an edge
    enable = 1'b0;
    t0 = tick_cnt;
    repeat (3) pulse(8, 8);
    check("t4_ticks", 32'(tick_cnt - t0), 32'd3);
    check("t4_hold", 32'(bcd_out), 32'h0000);
    enable = 1'b1;
    pulse(8, 8);
    check("t4_bcd_1", 32'(bcd_out), 32'h0001);
    divider_clk = 1'b1;
    repeat (2) cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("t4_clr_tick", 32'(tick), 32'h1);
    check("t4_clr_bcd", 32'(bcd_out), 32'h0000);

    // 5: stall detection and recovery
    first_stall = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 6) divider_clk = 1'b0;
      cycle();
      if (stalled === 1'b1 && first_stall == 0) first_stall = i;
    end
    check("t5_stall_delay", 32'(first_stall), 32'd20);
    high_cnt = 0;
    repeat (50) begin
      cycle();
      if (stalled === 1'b1) high_cnt++;
    end
    check("t5_stall_hold", 32'(high_cnt), 32'd50);
    divider_clk = 1'b1;
    repeat (2) cycle();
    check("t5_pre_stalled", 32'(stalled), 32'h1);
    cycle();
    check("t5_rec_tick", 32'(tick), 32'h1);
    check("t5_rec_stalled", 32'(stalled), 32'h0);
    repeat (5) cycle();
    divider_clk = 1'b0;
    repeat (8) cycle();

    // randomized widths, enable and occasional clear
    for (int e = 0; e < 60; e++) begin
      int hi, lo;
      hi = $urandom_range(3, 9);
      lo = $urandom_range(3, 9);
      enable = ($urandom_range(0, 3) != 0);
      divider_clk = 1'b1;
      repeat (hi) begin
        clear = ($urandom_range(0, 24) == 0);
        cycle();
      end
      clear = 1'b0;
      divider_clk = 1'b0;
      repeat (lo) cycle();
    end
    if ($urandom_range(0, 1) == 1) repeat (30) cycle();
    enable = 1'b1;

    // 6: reset mid-count with divider_clk high
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    repeat (41) pulse(3, 3);
    divider_clk = 1'b1;
    repeat (5) cycle();
    check("t6_pre_bcd", 32'(bcd_out), 32'h0042);
    do_reset();
    t0 = tick_cnt;
    repeat (10) cycle();
    check("t6_no_tick", 32'(tick_cnt - t0), 32'd0);
    check("t6_bcd_0", 32'(bcd_out), 32'h0000);
    divider_clk = 1'b0;
    repeat (4) cycle();
    pulse(4, 4);
    check("t6_bcd_1", 32'(bcd_out), 32'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
